// File: rtl/scan_sequencer.sv
// scan_sequencer: free-running scan timebase, scan-start edge qualification,
// LTR/RTL direction tracking and per-direction averaged full-line lengths.
module scan_sequencer #(
  parameter int          AVG_SHIFT  = 3,
  parameter int          MIN_SCAN   = 1000,
  parameter int          MAX_SCAN   = 2000000,
  parameter int          LOCK_COUNT = 4,
  // Reset value of the timestamp; leave at zero in the system, a non-zero
  // value lets a simulation reach the 32-bit wrap quickly.
  parameter logic [31:0] TIME_INIT  = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        scan_edge_in,
  output logic [31:0] sig_time,
  output logic        sync_start,
  output logic        dir,
  output logic [31:0] afll_ltr,
  output logic [31:0] afll_rtl,
  output logic        locked,
  output logic        scan_fault
);

  localparam int            CW       = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] GOOD_MAX = CW'(LOCK_COUNT);
  localparam logic [31:0]   MIN_T    = 32'(MIN_SCAN);
  localparam logic [31:0]   MAX_T    = 32'(MAX_SCAN);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_FIRST, ST_SCAN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   sig_time_q, sig_time_d;
  logic [31:0]   start_time_q, start_time_d;
  logic          edge_prev_q, edge_prev_d;
  logic          dir_q, dir_d;
  logic [31:0]   afll_ltr_q, afll_ltr_d;
  logic [31:0]   afll_rtl_q, afll_rtl_d;
  logic [1:0]    seeded_q, seeded_d;
  logic [CW-1:0] good_cnt_q, good_cnt_d;
  logic          locked_q, locked_d;
  logic          sync_start_q, sync_start_d;
  logic          scan_fault_q, scan_fault_d;

  logic               scan_edge;
  logic [31:0]        elapsed;
  logic [31:0]        avg_cur;
  logic [31:0]        avg_new;
  logic signed [32:0] diff_s;
  logic signed [32:0] avg_sum;
  logic [32:0]        abs_diff;
  logic               in_tol;
  logic [31:0]        upd_avg;
  logic               upd_good;
  logic               unused_sum_msb;

  // Datapath: elapsed time, deviation from the running average, tolerance and EMA step.
  always_comb begin
    scan_edge = scan_edge_in & ~edge_prev_q;
    elapsed   = sig_time_q - start_time_q;
    avg_cur   = dir_q ? afll_rtl_q : afll_ltr_q;
    diff_s    = $signed({1'b0, elapsed}) - $signed({1'b0, avg_cur});
    abs_diff  = diff_s[32] ? $unsigned(-diff_s) : $unsigned(diff_s);
    in_tol    = abs_diff <= {3'b000, avg_cur[31:2]};
    avg_sum   = $signed({1'b0, avg_cur}) + (diff_s >>> AVG_SHIFT);
    avg_new   = avg_sum[31:0];
  end

  // The sum's sign bit is dropped on purpose: the average truncates to 32 bits.
  assign unused_sum_msb = avg_sum[32];

  // Next-state logic: sequencer FSM, average update, lock tracking and pulses.
  always_comb begin
    state_d      = state_q;
    sig_time_d   = sig_time_q + 32'd1;
    start_time_d = start_time_q;
    edge_prev_d  = scan_edge_in;
    dir_d        = dir_q;
    afll_ltr_d   = afll_ltr_q;
    afll_rtl_d   = afll_rtl_q;
    seeded_d     = seeded_q;
    good_cnt_d   = good_cnt_q;
    locked_d     = locked_q;
    sync_start_d = 1'b0;
    scan_fault_d = 1'b0;
    upd_avg      = avg_new;
    upd_good     = in_tol;

    if (!enable) begin
      // Disable wins over any same-cycle edge; averages and seeds are kept.
      state_d    = ST_IDLE;
      dir_d      = 1'b0;
      locked_d   = 1'b0;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_FIRST;

        ST_WAIT_FIRST: begin
          if (scan_edge) begin
            start_time_d = sig_time_q;
            sync_start_d = 1'b1;
            state_d      = ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (scan_edge && (elapsed >= MIN_T)) begin
            // Accepted scan: the finished direction is the old dir.
            sync_start_d = 1'b1;
            start_time_d = sig_time_q;
            dir_d        = ~dir_q;
            if (!seeded_q[dir_q]) begin
              upd_avg  = elapsed;
              upd_good = 1'b1;
            end
            seeded_d[dir_q] = 1'b1;
            if (dir_q) afll_rtl_d = upd_avg;
            else       afll_ltr_d = upd_avg;
            if (upd_good) begin
              if (good_cnt_q != GOOD_MAX) good_cnt_d = good_cnt_q + CW'(1);
              locked_d = (good_cnt_d == GOOD_MAX);
            end else begin
              good_cnt_d = '0;
              locked_d   = 1'b0;
            end
          end else if (elapsed == MAX_T) begin
            // No usable edge within the window: restart from the first edge.
            scan_fault_d = 1'b1;
            locked_d     = 1'b0;
            good_cnt_d   = '0;
            dir_d        = 1'b0;
            state_d      = ST_WAIT_FIRST;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sig_time_q   <= TIME_INIT;
      start_time_q <= 32'd0;
      edge_prev_q  <= 1'b0;
      dir_q        <= 1'b0;
      afll_ltr_q   <= 32'd0;
      afll_rtl_q   <= 32'd0;
      seeded_q     <= 2'b00;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      sync_start_q <= 1'b0;
      scan_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sig_time_q   <= sig_time_d;
      start_time_q <= start_time_d;
      edge_prev_q  <= edge_prev_d;
      dir_q        <= dir_d;
      afll_ltr_q   <= afll_ltr_d;
      afll_rtl_q   <= afll_rtl_d;
      seeded_q     <= seeded_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      sync_start_q <= sync_start_d;
      scan_fault_q <= scan_fault_d;
    end
  end

  assign sig_time   = sig_time_q;
  assign sync_start = sync_start_q;
  assign dir        = dir_q;
  assign afll_ltr   = afll_ltr_q;
  assign afll_rtl   = afll_rtl_q;
  assign locked     = locked_q;
  assign scan_fault = scan_fault_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed bench for scan_sequencer with hand-computed expectations.
`timescale 1ns/1ps
module tb_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, scan_edge_in;
  logic        enable_w, scan_edge_w;
  logic [31:0] sig_time, afll_ltr, afll_rtl;
  logic        sync_start, dir, locked, scan_fault;
  logic [31:0] sig_time_w, afll_ltr_w, afll_rtl_w;
  logic        sync_start_w, dir_w, locked_w, scan_fault_w;

  int checks = 0;
  int errors = 0;

  scan_sequencer #(
    .AVG_SHIFT(2), .MIN_SCAN(10), .MAX_SCAN(1000), .LOCK_COUNT(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .scan_edge_in(scan_edge_in),
    .sig_time(sig_time), .sync_start(sync_start), .dir(dir),
    .afll_ltr(afll_ltr), .afll_rtl(afll_rtl), .locked(locked), .scan_fault(scan_fault)
  );

  // Second instance starts its timestamp just below the wrap point.
  scan_sequencer #(
    .AVG_SHIFT(2), .MIN_SCAN(10), .MAX_SCAN(1000), .LOCK_COUNT(4),
    .TIME_INIT(32'hFFFF_FF00)
  ) dut_w (
    .clk(clk), .reset(reset), .enable(enable_w), .scan_edge_in(scan_edge_w),
    .sig_time(sig_time_w), .sync_start(sync_start_w), .dir(dir_w),
    .afll_ltr(afll_ltr_w), .afll_rtl(afll_rtl_w), .locked(locked_w), .scan_fault(scan_fault_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise the selected edge input for one cycle; returns in the cycle after the edge.
  task automatic edge_pulse(input bit wrap_dut);
    if (wrap_dut) scan_edge_w = 1'b1;
    else          scan_edge_in = 1'b1;
    step();
    scan_edge_w  = 1'b0;
    scan_edge_in = 1'b0;
  endtask

  // Called in the cycle after an edge; places the next edge len cycles after it.
  task automatic scan(input bit wrap_dut, input int len);
    step();
    chk("sync_one_cycle", wrap_dut ? sync_start_w : sync_start, 32'd0);
    repeat (len - 2) step();
    edge_pulse(wrap_dut);
    $display("scan dut=%0d len=%0d", wrap_dut, len);
  endtask

  // Check the visible state of the main instance in one go.
  task automatic chk_main(input string tag, input logic s, input logic d, input logic l,
                          input logic [31:0] al, input logic [31:0] ar);
    chk({tag, "_sync"},   sync_start, s);
    chk({tag, "_dir"},    dir, d);
    chk({tag, "_locked"}, locked, l);
    chk({tag, "_ltr"},    afll_ltr, al);
    chk({tag, "_rtl"},    afll_rtl, ar);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; scan_edge_in = 1'b0;
    enable_w = 1'b0; scan_edge_w = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_sig_time", sig_time, 32'd0);
    chk("rst_fault", scan_fault, 32'd0);
    chk_main("rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_sig_time_w", sig_time_w, 32'hFFFF_FF00);

    // Timestamp runs with enable low
    reset = 1'b0;
    step();
    chk("time_1", sig_time, 32'd1);
    chk("time_w_1", sig_time_w, 32'hFFFF_FF01);
    step();
    chk("time_2", sig_time, 32'd2);

    // Wrap: first edge at 0xFFFFFF04, second 300 cycles later at 0x30
    enable_w = 1'b1;
    step(); step();
    edge_pulse(1'b1);
    chk("wrap_first_sync", sync_start_w, 32'd1);
    scan(1'b1, 300);
    chk("wrap_ltr", afll_ltr_w, 32'd300);
    chk("wrap_dir", dir_w, 32'd1);
    chk("wrap_sync", sync_start_w, 32'd1);
    chk("wrap_time", sig_time_w, 32'h31);
    scan(1'b1, 300);
    chk("wrap_rtl", afll_rtl_w, 32'd300);
    chk("wrap_dir2", dir_w, 32'd0);

    // Basic lock at 200
    enable = 1'b1;
    step(); step();
    edge_pulse(1'b0);
    chk_main("first", 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    scan(1'b0, 200); chk_main("lock1", 1'b1, 1'b1, 1'b0, 32'd200, 32'd0);
    scan(1'b0, 200); chk_main("lock2", 1'b1, 1'b0, 1'b0, 32'd200, 32'd200);
    scan(1'b0, 200); chk_main("lock3", 1'b1, 1'b1, 1'b0, 32'd200, 32'd200);
    scan(1'b0, 200); chk_main("lock4", 1'b1, 1'b0, 1'b1, 32'd200, 32'd200);

    // Averaging: LTR 240 -> 200 + 40/4
    scan(1'b0, 240); chk_main("avg", 1'b1, 1'b1, 1'b1, 32'd210, 32'd200);

    // Outlier: RTL 300 -> 200 + 100/4, lock drops
    scan(1'b0, 300); chk_main("outlier", 1'b1, 1'b0, 1'b0, 32'd210, 32'd225);

    // Re-lock after four good scans (arithmetic shift rounds toward -inf)
    scan(1'b0, 200); chk_main("relock1", 1'b1, 1'b1, 1'b0, 32'd207, 32'd225);
    scan(1'b0, 200); chk_main("relock2", 1'b1, 1'b0, 1'b0, 32'd207, 32'd218);
    scan(1'b0, 200); chk_main("relock3", 1'b1, 1'b1, 1'b0, 32'd205, 32'd218);
    scan(1'b0, 200); chk_main("relock4", 1'b1, 1'b0, 1'b1, 32'd205, 32'd213);

    // Glitch 5 cycles after the accepted edge is ignored
    repeat (4) step();
    edge_pulse(1'b0);
    chk_main("glitch", 1'b0, 1'b0, 1'b1, 32'd205, 32'd213);
    repeat (194) step();
    edge_pulse(1'b0);
    chk_main("after_glitch", 1'b1, 1'b1, 1'b1, 32'd203, 32'd213);

    // Disable mid-scan with a simultaneous edge: edge dropped, IDLE state forced
    repeat (50) step();
    enable = 1'b0; scan_edge_in = 1'b1;
    step();
    scan_edge_in = 1'b0;
    chk_main("disable", 1'b0, 1'b0, 1'b0, 32'd203, 32'd213);

    // Re-enable: first edge only restarts timing
    enable = 1'b1;
    step(); step();
    edge_pulse(1'b0);
    chk_main("reenable", 1'b1, 1'b0, 1'b0, 32'd203, 32'd213);

    // Edge exactly at elapsed == MAX_SCAN is accepted (797 > 50: out of tolerance)
    scan(1'b0, 1000);
    chk_main("max_edge", 1'b1, 1'b1, 1'b0, 32'd402, 32'd213);
    chk("max_edge_fault", scan_fault, 32'd0);

    // Timeout: fault the cycle after elapsed reaches MAX_SCAN
    repeat (999) step();
    chk("pre_timeout_fault", scan_fault, 32'd0);
    step();
    chk("timeout_fault", scan_fault, 32'd1);
    chk("timeout_dir", dir, 32'd0);
    chk("timeout_locked", locked, 32'd0);
    step();
    chk("timeout_one_cycle", scan_fault, 32'd0);

    // Next edge after timeout: sync only, averages held
    repeat (50) step();
    edge_pulse(1'b0);
    chk_main("post_timeout", 1'b1, 1'b0, 1'b0, 32'd402, 32'd213);

    // Reset mid-scan returns everything to reset values
    repeat (20) step();
    reset = 1'b1;
    step();
    chk_main("mid_reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("mid_reset_fault", scan_fault, 32'd0);
    chk("mid_reset_time", sig_time, 32'd0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
